pid_loop_sequencer: RTL and testbench

Sequences one control-loop iteration of the wall follower for each sample tick from the clock-enable divider. The order is: start sensor acquisition, wait for sensor done, start PID compute, wait for PID done, then strobe the PWM register update. It sits between the tick divider and the sensor, PID and PWM blocks. It also enforces per-stage timeouts and counts ticks that arrive while an iteration is still in flight (overruns).

---
 rtl/pid_loop_sequencer.sv | 140 ++++++++++++++
 tb/tb_pid_loop_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_loop_sequencer.sv
// One wall-follower control iteration per sample tick: sense, compute, PWM update,
// with per-stage timeouts and a saturating count of ticks dropped while busy.
module pid_loop_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int OVR_W          = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             clear_err,
  input  logic             sensor_done,
  input  logic             pid_done,
  output logic             sensor_start,
  output logic             pid_start,
  output logic             pwm_update,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       fault_stage,
  output logic [OVR_W-1:0] overrun_count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SENSE   = 2'd1,
    S_COMPUTE = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sensor_start_q, sensor_start_d;
  logic             pid_start_q, pid_start_d;
  logic             pwm_update_q, pwm_update_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic [1:0]       fault_stage_q, fault_stage_d;
  logic [OVR_W-1:0] overrun_q, overrun_d;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    sensor_start_d = 1'b0;
    pid_start_d    = 1'b0;
    pwm_update_d   = 1'b0;
    timeout_err_d  = timeout_err_q;
    fault_stage_d  = fault_stage_q;
    overrun_d      = overrun_q;

    case (state_q)
      // UPDATE behaves like IDLE on its closing edge so back-to-back ticks are accepted
      S_IDLE, S_UPDATE: begin
        state_d = S_IDLE;
        if (tick_in && enable) begin
          state_d        = S_SENSE;
          timer_d        = '0;
          sensor_start_d = 1'b1;
        end
      end
      S_SENSE: begin
        if (sensor_done) begin
          state_d     = S_COMPUTE;
          timer_d     = '0;
          pid_start_d = 1'b1;
        end else if (timer_q == TLAST) begin
          state_d       = S_IDLE;
          timer_d       = '0;
          timeout_err_d = 1'b1;
          fault_stage_d = 2'b01;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (pid_done) begin
          state_d      = S_UPDATE;
          timer_d      = '0;
          pwm_update_d = 1'b1;
        end else if (timer_q == TLAST) begin
          state_d       = S_IDLE;
          timer_d       = '0;
          timeout_err_d = 1'b1;
          fault_stage_d = 2'b10;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A tick while waiting on a stage is dropped and counted
    if (tick_in && (state_q == S_SENSE || state_q == S_COMPUTE) && (overrun_q != '1)) begin
      overrun_d = overrun_q + 1'b1;
    end

    if (clear_err) begin
      timeout_err_d = 1'b0;
      fault_stage_d = 2'b00;
      overrun_d     = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      sensor_start_q <= 1'b0;
      pid_start_q    <= 1'b0;
      pwm_update_q   <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      fault_stage_q  <= 2'b00;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      sensor_start_q <= sensor_start_d;
      pid_start_q    <= pid_start_d;
      pwm_update_q   <= pwm_update_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      fault_stage_q  <= fault_stage_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sensor_start  = sensor_start_q;
  assign pid_start     = pid_start_q;
  assign pwm_update    = pwm_update_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign fault_stage   = fault_stage_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Bench for pid_loop_sequencer: directed scenarios plus random stimulus, all
// outputs compared every cycle against an iteration-level model.
module tb_pid_loop_sequencer;

  localparam int TO    = 8;
  localparam int OVR_W = 2;
  localparam int OMAX  = (1 << OVR_W) - 1;

  logic clk_in = 1'b0;
  logic reset_in;
  logic tick_in, enable, clear_err, sensor_done, pid_done;
  logic sensor_start, pid_start, pwm_update, busy, timeout_err;
  logic [1:0] fault_stage;
  logic [OVR_W-1:0] overrun_count;

  pid_loop_sequencer #(.TIMEOUT_CYCLES(TO), .OVR_W(OVR_W)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .tick_in(tick_in), .enable(enable),
    .clear_err(clear_err), .sensor_done(sensor_done), .pid_done(pid_done),
    .sensor_start(sensor_start), .pid_start(pid_start), .pwm_update(pwm_update),
    .busy(busy), .timeout_err(timeout_err), .fault_stage(fault_stage),
    .overrun_count(overrun_count)
  );

  always #5 clk_in = ~clk_in;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Iteration-level model: phase 0 idle, 1 sensing, 2 computing, 3 updating;
  // 'waited' counts edges spent in the current wait phase.
  typedef struct packed {
    int ph;
    int waited;
    int ss;
    int ps;
    int pu;
    int bsy;
    int err;
    int fault;
    int ovr;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic t, logic en, logic clr, logic sd, logic pd);
    model_t n = c;
    n.ss = 0; n.ps = 0; n.pu = 0;
    if (c.ph == 1 || c.ph == 2) begin
      if (t) n.ovr = (c.ovr >= OMAX) ? OMAX : c.ovr + 1;
      n.waited = c.waited + 1;
      if ((c.ph == 1 && sd) || (c.ph == 2 && pd)) begin
        n.ph = c.ph + 1;
        n.waited = 0;
        if (c.ph == 1) n.ps = 1; else n.pu = 1;
      end else if (n.waited == TO) begin
        n.err = 1;
        n.fault = c.ph;
        n.ph = 0;
        n.waited = 0;
      end
    end else begin
      n.ph = 0;
      if (t && en) begin
        n.ph = 1;
        n.waited = 0;
        n.ss = 1;
      end
    end
    if (clr) begin
      n.err = 0; n.fault = 0; n.ovr = 0;
    end
    n.bsy = (n.ph != 0) ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) m <= '0;
    else          m <= step(m, tick_in, enable, clear_err, sensor_done, pid_done);
  end

  int edge_n = 0;
  int cnt_ss = 0, cnt_ps = 0, cnt_pu = 0, cnt_busy = 0;
  int ss_at = 0, ps_at = 0, pu_at = 0;

  always begin
    @(posedge clk_in);
    edge_n++;
    #2;
    if (!reset_in) begin
      chk("sensor_start", int'(sensor_start), m.ss);
      chk("pid_start", int'(pid_start), m.ps);
      chk("pwm_update", int'(pwm_update), m.pu);
      chk("busy", int'(busy), m.bsy);
      chk("timeout_err", int'(timeout_err), m.err);
      chk("fault_stage", int'(fault_stage), m.fault);
      chk("overrun_count", int'(overrun_count), m.ovr);
      if (sensor_start) begin cnt_ss++; ss_at = edge_n; end
      if (pid_start)    begin cnt_ps++; ps_at = edge_n; end
      if (pwm_update)   begin cnt_pu++; pu_at = edge_n; end
      if (busy) cnt_busy++;
    end
  end

  task automatic cyc(input logic t, input logic e, input logic c, input logic sd, input logic pd);
    @(negedge clk_in);
    tick_in = t; enable = e; clear_err = c; sensor_done = sd; pid_done = pd;
  endtask

  task automatic settle();
    @(posedge clk_in);
    #3;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_sensor_start"}, int'(sensor_start), 0);
    chk({nm, "_pid_start"}, int'(pid_start), 0);
    chk({nm, "_pwm_update"}, int'(pwm_update), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_timeout_err"}, int'(timeout_err), 0);
    chk({nm, "_fault_stage"}, int'(fault_stage), 0);
    chk({nm, "_overrun"}, int'(overrun_count), 0);
  endtask

  int b_ss, b_ps, b_pu, b_busy;

  initial begin
    reset_in = 1'b1;
    tick_in = 0; enable = 0; clear_err = 0; sensor_done = 0; pid_done = 0;
    repeat (3) @(posedge clk_in);
    #3;
    chk_all_zero("reset");
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (3) cyc(0, 1, 0, 0, 0);

    // Nominal: done 3 cycles after sensor_start, pid_done 2 cycles after pid_start
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    repeat (2) cyc(0, 1, 0, 0, 0);
    settle();
    chk("nom_pid_start_delay", ps_at - ss_at, 4);
    chk("nom_pwm_delay", pu_at - ss_at, 7);
    chk("nom_busy_end", int'(busy), 0);
    chk("nom_no_err", int'(timeout_err), 0);

    // Sensor timeout: exactly 8 busy cycles, no pid_start
    b_ps = cnt_ps; b_busy = cnt_busy; b_pu = cnt_pu;
    cyc(1, 1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0, 0);
    settle();
    chk("sto_err", int'(timeout_err), 1);
    chk("sto_fault", int'(fault_stage), 1);
    chk("sto_no_pid_start", cnt_ps - b_ps, 0);
    chk("sto_no_pwm", cnt_pu - b_pu, 0);
    chk("sto_busy_cycles", cnt_busy - b_busy, 8);

    // sensor_done on the 8th SENSE cycle still wins
    b_ps = cnt_ps; b_pu = cnt_pu;
    cyc(1, 1, 0, 0, 0);
    repeat (7) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    repeat (2) cyc(0, 1, 0, 0, 0);
    settle();
    chk("sto_last_pid_start", cnt_ps - b_ps, 1);
    chk("sto_last_pwm", cnt_pu - b_pu, 1);

    // PID timeout then clear
    b_pu = cnt_pu;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    settle();
    chk("pto_err", int'(timeout_err), 1);
    chk("pto_fault", int'(fault_stage), 2);
    chk("pto_no_pwm", cnt_pu - b_pu, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    settle();
    chk("clr_err", int'(timeout_err), 0);
    chk("clr_fault", int'(fault_stage), 0);

    // Overrun saturation, then tick coincident with clear
    cyc(1, 1, 0, 0, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    settle();
    chk("ovr_sat", int'(overrun_count), 3);
    cyc(1, 1, 1, 0, 0);
    settle();
    chk("ovr_clear_wins", int'(overrun_count), 0);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);

    // Enable gating
    b_ss = cnt_ss;
    repeat (5) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    settle();
    chk("en_no_start", cnt_ss - b_ss, 0);
    chk("en_no_ovr", int'(overrun_count), 0);
    b_ss = cnt_ss; b_pu = cnt_pu;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    settle();
    chk("en_drop_pwm", cnt_pu - b_pu, 1);
    chk("en_drop_next_tick", cnt_ss - b_ss, 1);

    // Async reset while pid_start is high
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    settle();
    chk("rst_pid_start_before", int'(pid_start), 1);
    reset_in = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk_in);
    reset_in = 1'b0;
    cyc(1, 1, 0, 0, 0);
    settle();
    chk("rst_fresh_start", int'(sensor_start), 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    repeat (2) cyc(0, 1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(3) == 0), ($urandom_range(9) < 8), ($urandom_range(31) == 0),
          ($urandom_range(9) < 3), ($urandom_range(9) < 3));
    end
    cyc(0, 0, 0, 0, 0);
    settle();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
